amstrad_mmu_io_writer: RTL and testbench
========================================

Name: amstrad_mmu_io_writer

Overview:
- Bus-master sequencer that drives the CPC gate-array/PAL I/O write protocol; the initiator side of the MMU's write decoder.
- On request, it acquires the Z80 I/O bus and issues up to two I/O write strobes:
  - the 7Fxx PAL RAM-config write;
  - the DFxx upper-ROM select write.
- Used by snapshot restore and the OSD reset path to force a RAM/ROM mapping without CPU involvement.

Parameters:
SETUP_LEN, 1, cycles io_A/io_D are driven before io_WR rises (1..15)
PULSE_LEN, 2, cycles io_WR is held high (1..15)
HOLD_LEN, 1, cycles io_A/io_D stay driven after io_WR falls (1..15)

Ports:
CLK  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  request a sequence; sampled only in IDLE
do_ram  in  1  include the 7Fxx RAM-config write
do_rom  in  1  include the DFxx ROM-select write
ram_cfg  in  8  PAL MMR byte; bits 7:6 forced to 2'b11 on output
page_hi  in  1  upper 512KB page select; drives io_A[8] = ~page_hi
rom_sel  in  8  upper ROM number
bus_gnt  in  1  bus grant from CPU arbiter
bus_req  out  1  bus request
drive_en  out  1  io_A/io_D/io_WR are valid and must be muxed onto the bus
io_A  out  16  I/O address
io_D  out  8  I/O data
io_WR  out  1  I/O write strobe; the MMU samples its rising edge
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on normal completion
abort  out  1  one-cycle pulse when the grant is lost mid-sequence

Behaviour:
- Reset (reset_n=0 at a clock edge, any state):
  - next cycle state=IDLE;
  - bus_req, drive_en, io_WR, busy, done, abort all 0;
  - io_A=16'h0000, io_D=8'h00;
  - all counters 0.
- IDLE, start=1:
  - if do_ram|do_rom=1: latch ram_cfg, page_hi, rom_sel, do_ram, do_rom; go to REQ with busy=1 and bus_req=1.
  - if do_ram=do_rom=0: no bus request; done=1 for one cycle; stay IDLE.
- start is ignored while busy.
- REQ: hold bus_req=1 until bus_gnt=1; no timeout. Next state is SETUP for the first enabled write (RAM before ROM).
- Write to RAM config:
  - io_A = {7'b0111111, ~page_hi_l, 8'h00} (7F00, or 7E00 when page_hi=1);
  - io_D = {2'b11, ram_cfg_l[5:0]}.
- Write to ROM select:
  - io_A = 16'hDF00;
  - io_D = rom_sel_l.
- Each write runs SETUP → STROBE → HOLD:
  - SETUP: SETUP_LEN cycles; drive_en=1, io_WR=0.
  - STROBE: PULSE_LEN cycles; io_WR=1.
  - HOLD: HOLD_LEN cycles; io_WR=0.
  - io_A/io_D remain stable through all three phases.
- Back-to-back writes: HOLD of write 1 goes straight to SETUP of write 2, so io_WR is low for at least HOLD_LEN+SETUP_LEN cycles between strobes. This guarantees two distinct rising edges.
- RELEASE, one cycle after the last HOLD:
  - drive_en=0, bus_req=0, busy=0, done=1;
  - io_A/io_D return to 0;
  - next state IDLE.
- Latency: with start sampled at edge N and bus_gnt already high, done=1 in cycle N+2+n*(SETUP_LEN+PULSE_LEN+HOLD_LEN), where n = number of enabled writes. Each cycle of grant wait adds 1.
- Grant loss: if bus_gnt=0 in any SETUP/STROBE/HOLD cycle, the next cycle is IDLE:
  - io_WR=0, drive_en=0, bus_req=0, busy=0;
  - abort=1 for one cycle; done stays 0.
  - A strobe already issued is not retried.
- Inputs other than bus_gnt are ignored after latching; changing them mid-sequence has no effect.
- done and abort are never asserted together.
- io_WR=1 implies drive_en=1 and bus_gnt was 1 in the previous cycle.

Test Plan:
- Reset: reset_n=0 mid-STROBE (io_WR=1) → next cycle io_WR=0, bus_req=0, busy=0, drive_en=0; a following start runs a full sequence normally.
- Full sequence, bus_gnt tied 1, defaults: start with do_ram=1, do_rom=1, ram_cfg=8'h05, page_hi=0, rom_sel=8'h07 at edge 0 → bus_req high from cycle 1; io_A=7F00, io_D=C5 in cycles 2–5 with io_WR=1 in 3–4; io_A=DF00, io_D=07 in cycles 6–9 with io_WR=1 in 7–8; done=1 and busy=0 in cycle 10. A connected MMU model then shows RAMmap=5 and ROMbank=7 (with rom_map[7]=1).
- Grant wait and page_hi: do_ram only, page_hi=1, ram_cfg=8'h3A (bits 7:6 not 11), bus_gnt delayed 5 cycles → drive_en stays 0 during the wait; strobe shows io_A=7E00, io_D=FA; done arrives 5 cycles later than the no-wait case.
- Grant loss: drop bus_gnt during the second write's STROBE → next cycle io_WR=0, abort=1, done=0; exactly one complete plus one truncated rising edge of io_WR is observed.
- Degenerate and ignored requests:
  - start with do_ram=do_rom=0 → done pulse in cycle 1, bus_req never asserted;
  - start re-pulsed while busy → no effect.
- Timing stress: SETUP_LEN=1, PULSE_LEN=1, HOLD_LEN=1 → two single-cycle strobes separated by exactly 2 low cycles; each strobe produces exactly one MMU-detected rising edge.

Source files
------------

// File: rtl/amstrad_mmu_io_writer.sv
// amstrad_mmu_io_writer
//   Bus-master sequencer for the CPC gate-array/PAL I/O write protocol. On a
//   request it acquires the Z80 I/O bus and issues up to two I/O write strobes:
//   the 7Fxx PAL RAM-config write, then the DFxx upper-ROM select write.
//   It lets the snapshot restore and OSD reset paths force a RAM/ROM mapping
//   without involving the CPU.
//
// Ports
//   CLK        system clock, rising edge
//   reset_n    synchronous active-low reset
//   start      request a sequence (sampled only in IDLE)
//   do_ram     include the 7Fxx RAM-config write
//   do_rom     include the DFxx ROM-select write
//   ram_cfg    PAL MMR byte (bits 7:6 forced to 2'b11 on the bus)
//   page_hi    upper 512KB page select, drives io_A[8] = ~page_hi
//   rom_sel    upper ROM number
//   bus_gnt    bus grant from the CPU arbiter
//   bus_req    bus request
//   drive_en   io_A/io_D/io_WR are valid and must be muxed onto the bus
//   io_A       I/O address
//   io_D       I/O data
//   io_WR      I/O write strobe (the MMU samples its rising edge)
//   busy       sequence in progress
//   done       one-cycle pulse on normal completion
//   abort      one-cycle pulse when the grant is lost mid-sequence
//   dbg_state  current FSM state, for observation only
//
// Handshake: bus_req is a level request. It is raised when a sequence is
// accepted and held until the sequence completes or aborts. The bus is ours
// in any cycle where bus_gnt=1; bus_gnt=0 while we drive the bus means the
// arbiter has taken it back, and the sequence aborts on the following edge.
module amstrad_mmu_io_writer #(
  parameter int unsigned SETUP_LEN = 1,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned HOLD_LEN  = 1
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        start,
  input  logic        do_ram,
  input  logic        do_rom,
  input  logic [7:0]  ram_cfg,
  input  logic        page_hi,
  input  logic [7:0]  rom_sel,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic        drive_en,
  output logic [15:0] io_A,
  output logic [7:0]  io_D,
  output logic        io_WR,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SETUP   = 3'd2,
    S_STROBE  = 3'd3,
    S_HOLD    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  // Counters are loaded with length-1 and count down to zero.
  localparam logic [3:0] SETUP_M1 = 4'(SETUP_LEN - 1);
  localparam logic [3:0] PULSE_M1 = 4'(PULSE_LEN - 1);
  localparam logic [3:0] HOLD_M1  = 4'(HOLD_LEN - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       do_ram_l;
  logic       do_rom_l;
  logic [5:0] ram_cfg_l;
  logic       page_hi_l;
  logic [7:0] rom_sel_l;
  logic       on_rom;     // 0: current write is the RAM-config write

  logic on_bus;
  assign on_bus    = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      do_ram_l  <= 1'b0;
      do_rom_l  <= 1'b0;
      ram_cfg_l <= '0;
      page_hi_l <= 1'b0;
      rom_sel_l <= '0;
      on_rom    <= 1'b0;
      bus_req   <= 1'b0;
      drive_en  <= 1'b0;
      io_A      <= '0;
      io_D      <= '0;
      io_WR     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (on_bus && !bus_gnt) begin
        // Grant withdrawn: release everything at once, no retry.
        state    <= S_IDLE;
        cnt      <= '0;
        bus_req  <= 1'b0;
        drive_en <= 1'b0;
        io_WR    <= 1'b0;
        io_A     <= '0;
        io_D     <= '0;
        busy     <= 1'b0;
        abort    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (do_ram || do_rom) begin
                do_ram_l  <= do_ram;
                do_rom_l  <= do_rom;
                ram_cfg_l <= ram_cfg[5:0];
                page_hi_l <= page_hi;
                rom_sel_l <= rom_sel;
                bus_req   <= 1'b1;
                busy      <= 1'b1;
                state     <= S_REQ;
              end else begin
                // Nothing to write: acknowledge without touching the bus.
                done <= 1'b1;
              end
            end
          end
          S_REQ: begin
            if (bus_gnt) begin
              on_rom   <= !do_ram_l;
              drive_en <= 1'b1;
              io_WR    <= 1'b0;
              if (do_ram_l) begin
                io_A <= {7'b0111111, ~page_hi_l, 8'h00};
                io_D <= {2'b11, ram_cfg_l};
              end else begin
                io_A <= 16'hDF00;
                io_D <= rom_sel_l;
              end
              cnt   <= SETUP_M1;
              state <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (cnt == 4'd0) begin
              io_WR <= 1'b1;
              cnt   <= PULSE_M1;
              state <= S_STROBE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_STROBE: begin
            if (cnt == 4'd0) begin
              io_WR <= 1'b0;
              cnt   <= HOLD_M1;
              state <= S_HOLD;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_HOLD: begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else if (!on_rom && do_rom_l) begin
              // Chain straight into the ROM write; SETUP keeps io_WR low so
              // the MMU sees two separate rising edges.
              on_rom <= 1'b1;
              io_A   <= 16'hDF00;
              io_D   <= rom_sel_l;
              cnt    <= SETUP_M1;
              state  <= S_SETUP;
            end else begin
              drive_en <= 1'b0;
              bus_req  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              io_A     <= '0;
              io_D     <= '0;
              state    <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amstrad_mmu_io_writer.sv
module tb_amstrad_mmu_io_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        do_ram, do_rom, page_hi;
  logic [7:0]  ram_cfg, rom_sel;
  logic        start_a, gnt_a, start_b, gnt_b;

  logic        a_req, a_drv, a_wr, a_busy, a_done, a_abort;
  logic [15:0] a_A;
  logic [7:0]  a_D;
  logic [2:0]  a_st;
  logic        b_req, b_drv, b_wr, b_busy, b_done, b_abort;
  logic [15:0] b_A;
  logic [7:0]  b_D;
  logic [2:0]  b_st;

  // Default timing instance
  amstrad_mmu_io_writer u_dut (
    .CLK(clk), .reset_n(reset_n), .start(start_a), .do_ram(do_ram), .do_rom(do_rom),
    .ram_cfg(ram_cfg), .page_hi(page_hi), .rom_sel(rom_sel), .bus_gnt(gnt_a),
    .bus_req(a_req), .drive_en(a_drv), .io_A(a_A), .io_D(a_D), .io_WR(a_wr),
    .busy(a_busy), .done(a_done), .abort(a_abort), .dbg_state(a_st)
  );

  // Minimum timing instance (1/1/1)
  amstrad_mmu_io_writer #(.SETUP_LEN(1), .PULSE_LEN(1), .HOLD_LEN(1)) u_fast (
    .CLK(clk), .reset_n(reset_n), .start(start_b), .do_ram(do_ram), .do_rom(do_rom),
    .ram_cfg(ram_cfg), .page_hi(page_hi), .rom_sel(rom_sel), .bus_gnt(gnt_b),
    .bus_req(b_req), .drive_en(b_drv), .io_A(b_A), .io_D(b_D), .io_WR(b_wr),
    .busy(b_busy), .done(b_done), .abort(b_abort), .dbg_state(b_st)
  );

  // Simple MMU model on the default instance: decodes each io_WR rising edge.
  logic [2:0] ram_map;
  logic [7:0] rom_bank;
  initial begin
    ram_map  = 3'd0;
    rom_bank = 8'd0;
  end
  always @(posedge a_wr) begin
    if (a_A[15:14] == 2'b01 && a_D[7:6] == 2'b11) ram_map <= a_D[2:0];
    else if (!a_A[13]) rom_bank <= a_D;
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec(input logic req, drv, wr, bsy, dn, ab,
                                      input logic [15:0] A, input logic [7:0] D);
    return {2'b00, req, drv, wr, bsy, dn, ab, A, D};
  endfunction

  function automatic logic [31:0] obs_vec(input bit sel);
    if (sel) return vec(b_req, b_drv, b_wr, b_busy, b_done, b_abort, b_A, b_D);
    return vec(a_req, a_drv, a_wr, a_busy, a_done, a_abort, a_A, a_D);
  endfunction

  // Reference model: expected output per cycle after the start edge, built from
  // the list of writes, the grant wait d and an optional single-cycle grant drop.
  task automatic model_txn(input int s, input int p, input int h, input int d, input int drop,
                           input logic dr, input logic dm, input logic [7:0] cfg,
                           input logic ph, input logic [7:0] rs,
                           output int n_strobe, output int n_active);
    logic [15:0] addr[2];
    logic [7:0]  data[2];
    int n;
    int cyc;
    bit ab;
    n = 0;
    ab = 0;
    n_strobe = 0;
    exp_q.delete();
    if (dr) begin addr[n] = ph ? 16'h7E00 : 16'h7F00; data[n] = {2'b11, cfg[5:0]}; n++; end
    if (dm) begin addr[n] = 16'hDF00; data[n] = rs; n++; end
    if (n == 0) begin
      exp_q.push_back(vec(0, 0, 0, 0, 1, 0, 16'h0, 8'h0));
    end else begin
      for (int c = 1; c <= d + 1; c++) exp_q.push_back(vec(1, 0, 0, 1, 0, 0, 16'h0, 8'h0));
      cyc = d + 2;
      for (int w = 0; w < n && !ab; w++) begin
        for (int q = 0; q < s + p + h && !ab; q++) begin
          logic wr;
          wr = (q >= s) && (q < s + p);
          if (wr && q == s) n_strobe++;
          exp_q.push_back(vec(1, 1, wr, 1, 0, 0, addr[w], data[w]));
          if (cyc == drop) ab = 1;
          cyc++;
        end
      end
      if (ab) exp_q.push_back(vec(0, 0, 0, 0, 0, 1, 16'h0, 8'h0));
      else    exp_q.push_back(vec(0, 0, 0, 0, 1, 0, 16'h0, 8'h0));
    end
    n_active = exp_q.size();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
  endtask

  task automatic set_start_gnt(input bit sel, input logic st, input logic g);
    if (sel) begin start_b = st; gnt_b = g; start_a = 1'b0; gnt_a = 1'b1; end
    else     begin start_a = st; gnt_a = g; start_b = 1'b0; gnt_b = 1'b1; end
  endtask

  task automatic run_txn(input bit sel, input string tag, input int d, input int drop,
                         input logic dr, input logic dm, input logic [7:0] cfg,
                         input logic ph, input logic [7:0] rs);
    int s, p, h, n_strobe, n_active, rises;
    logic prev_wr, cur_wr;
    logic [31:0] o;
    s = 1; p = sel ? 1 : 2; h = 1;
    model_txn(s, p, h, d, drop, dr, dm, cfg, ph, rs, n_strobe, n_active);
    rises = 0;
    prev_wr = 1'b0;
    @(posedge clk); #1;
    do_ram = dr; do_rom = dm; ram_cfg = cfg; page_hi = ph; rom_sel = rs;
    set_start_gnt(sel, 1'b1, d == 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      int c;
      c = i + 1;
      @(posedge clk); #1;
      set_start_gnt(sel, (c < n_active) ? 1'($urandom_range(0, 1)) : 1'b0,
                    (c <= d || c == drop) ? 1'b0 : 1'b1);
      do_ram = 1'($urandom); do_rom = 1'($urandom); ram_cfg = 8'($urandom);
      page_hi = 1'($urandom); rom_sel = 8'($urandom);
      @(negedge clk);
      o = obs_vec(sel);
      check($sformatf("%s_c%0d", tag, c), o, exp_q[i]);
      cur_wr = o[27];
      if (cur_wr && !prev_wr) rises++;
      prev_wr = cur_wr;
    end
    check($sformatf("%s_edges", tag), 32'(rises), 32'(n_strobe));
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; gnt_a = 1'b1; start_b = 1'b0; gnt_b = 1'b1;
    do_ram = 1'b0; do_rom = 1'b0; ram_cfg = 8'h00; page_hi = 1'b0; rom_sel = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", obs_vec(0), 32'h0);
    check("reset_b", obs_vec(1), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full sequence with defaults, then the MMU model mapping
    run_txn(0, "full", 0, 0, 1, 1, 8'h05, 0, 8'h07);
    check("mmu_ram", 32'(ram_map), 32'd5);
    check("mmu_rom", 32'(rom_bank), 32'd7);

    // Grant wait of 5 cycles, page_hi=1, MMR bits forced
    run_txn(0, "wait", 5, 0, 1, 0, 8'h3A, 1, 8'h00);

    // Grant lost during the second write's strobe
    run_txn(0, "loss", 0, 7, 1, 1, 8'h12, 0, 8'h03);

    // Degenerate request
    run_txn(0, "degen", 0, 0, 0, 0, 8'hFF, 1, 8'hFF);

    // Minimum timing, both writes
    run_txn(1, "fast", 0, 0, 1, 1, 8'hC4, 0, 8'h0A);

    // Reset while strobing
    @(posedge clk); #1;
    do_ram = 1'b1; do_rom = 1'b0; ram_cfg = 8'h01; page_hi = 1'b0;
    set_start_gnt(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pre_wr", {31'b0, a_wr}, 32'h1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_post", obs_vec(0), 32'h0);
    reset_n = 1'b1;
    run_txn(0, "after_rst", 0, 0, 1, 1, 8'h2B, 1, 8'h11);

    // Randomized transactions on both instances
    for (int t = 0; t < 40; t++) begin
      bit sel;
      int d, drop, span;
      logic dr, dm;
      sel = 1'($urandom);
      dr = 1'($urandom); dm = 1'($urandom);
      d = $urandom_range(0, 4);
      span = (32'(dr) + 32'(dm)) * (sel ? 3 : 4);
      drop = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(d + 2, d + 2 + span);
      run_txn(sel, $sformatf("rnd%0d", t), d, drop, dr, dm, 8'($urandom), 1'($urandom),
              8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
